// File: rtl/pow2_row_scheduler_pkg.sv
// rtl/pow2_row_scheduler_pkg.sv - shared state type, constants and pow2 fraction table for the row scheduler
package pow2_row_scheduler_pkg;

  typedef enum logic {IDLE, STREAM} sched_state_t;

  localparam logic [15:0] ONE_Q15 = 16'h8000;
  localparam int POW2_SHIFT_LIMIT = 32;

  function automatic int sum_width(input int pow_bw, input int len_w);
    return pow_bw + len_w;
  endfunction

  // 2^(-frac/4) in Q1.15, indexed by the two fractional input bits
  function automatic logic [15:0] pow2_frac_lut(input logic [1:0] frac);
    case (frac)
      2'd0:    return ONE_Q15;
      2'd1:    return 16'h6BA2;
      2'd2:    return 16'h5A82;
      default: return 16'h4C1C;
    endcase
  endfunction

endpackage

// File: rtl/pow2_rr_arb.sv
// rtl/pow2_rr_arb.sv - combinational round-robin pick of the first set request at or after ptr
module pow2_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [NREQ-1:0]  grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int j;
    j         = 0;
    any       = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any         = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pow2_row_scheduler.sv
// rtl/pow2_row_scheduler.sv - shares one pow2 unit among row requesters, row-locked grants, row sum on last beat
module pow2_row_scheduler
  import pow2_row_scheduler_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int BW     = 8,
  parameter int FW     = 2,
  parameter int POW_BW = 16,
  parameter int POW_FW = 15,
  parameter int LEN_W  = 8,
  parameter int SUM_BW = sum_width(POW_BW, LEN_W),
  parameter int IDX_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [POW_BW-1:0]    out_data,
  output logic [IDX_W-1:0]     out_id,
  output logic                 out_last,
  output logic [SUM_BW-1:0]    out_sum
);

  localparam logic [POW_BW-1:0] POW_ONE = POW_BW'(1) << POW_FW;

  sched_state_t      state;
  logic [IDX_W-1:0]  grant;
  logic [NREQ-1:0]   grant_oh_q;
  logic [IDX_W-1:0]  rr_ptr;
  logic [SUM_BW-1:0] acc;
  logic [LEN_W-1:0]  cnt;

  logic              arb_any;
  logic [NREQ-1:0]   arb_oh;
  logic [IDX_W-1:0]  arb_idx;

  pow2_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .any       (arb_any),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  logic accept, beat_last;
  logic [BW-1:0]     x_raw, x_clamp;
  logic [BW:0]       mag;
  logic [BW-FW:0]    shift;
  logic [FW-1:0]     frac;
  logic [POW_BW-1:0] pow_base, pow_val;
  logic [SUM_BW:0]   sum_ext;
  logic [SUM_BW-1:0] sum_sat;

  assign req_ready = (state == STREAM && (!out_valid || out_ready)) ? grant_oh_q : '0;
  assign accept    = |(req_valid & req_ready);
  assign x_raw     = req_data[grant*BW +: BW];
  // The 2**LEN_W-th beat closes the row regardless of req_last
  assign beat_last = req_last[grant] | (cnt == {LEN_W{1'b1}});

  always_comb begin
    x_clamp  = (!x_raw[BW-1] && (x_raw != '0)) ? '0 : x_raw;
    mag      = -{x_clamp[BW-1], x_clamp};
    shift    = mag[BW:FW];
    frac     = mag[FW-1:0];
    pow_base = (frac == '0) ? POW_ONE : POW_BW'(pow2_frac_lut(2'(frac)));
    pow_val  = (int'(shift) >= POW2_SHIFT_LIMIT) ? '0 : (pow_base >> shift);
  end

  assign sum_ext = {1'b0, acc} + {{(SUM_BW + 1 - POW_BW){1'b0}}, pow_val};
  assign sum_sat = sum_ext[SUM_BW] ? {SUM_BW{1'b1}} : sum_ext[SUM_BW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_oh_q <= '0;
      rr_ptr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      out_last   <= 1'b0;
      out_sum    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= pow_val;
        out_id    <= grant;
        out_last  <= beat_last;
        out_sum   <= sum_sat;
        acc       <= sum_sat;
        cnt       <= cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arb_any) begin
            grant      <= arb_idx;
            grant_oh_q <= arb_oh;
            acc        <= '0;
            cnt        <= '0;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (accept && beat_last) begin
            state  <= IDLE;
            rr_ptr <= (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow2_row_scheduler.sv
// tb/tb_pow2_row_scheduler.sv - scoreboard bench for pow2_row_scheduler with directed rows
module tb_pow2_row_scheduler;

  localparam int NREQ = 4;
  localparam int BW   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*BW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [1:0]        out_id;
  logic              out_last;
  logic [23:0]       out_sum;

  pow2_row_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [7:0] d; logic l;} beat_t;
  typedef struct {logic [15:0] d; logic [1:0] id; logic l; logic [23:0] s;} exp_t;

  beat_t inq[$];
  exp_t  expq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    mon_en = 1'b1;
  logic [23:0] sum_m = '0;
  logic [NREQ-1:0] acc_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic in_beat(input int id, input logic [7:0] d, input logic l);
    beat_t b;
    b.id = id; b.d = d; b.l = l;
    inq.push_back(b);
  endtask

  task automatic exp_beat(input int id, input logic [15:0] d, input logic l);
    exp_t e;
    sum_m = sum_m + 24'(d);
    e.d = d; e.id = 2'(id); e.l = l; e.s = sum_m;
    expq.push_back(e);
    if (l) sum_m = '0;
  endtask

  task automatic present();
    logic [NREQ-1:0]    v;
    logic [NREQ-1:0]    l;
    logic [NREQ*BW-1:0] d;
    v = '0;
    l = '1;
    d = {NREQ{8'h11}};
    for (int k = 0; k < inq.size(); k++) begin
      int i;
      i = inq[k].id;
      if (!v[i]) begin
        v[i] = 1'b1;
        l[i] = inq[k].l;
        d[i*BW +: BW] = inq[k].d;
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((inq.size() != 0 || expq.size() != 0 || out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drained"}, (t < 2000) ? 32'd1 : 32'd0, 32'd1);
    if (t >= 2000) begin
      inq.delete();
      expq.delete();
    end
  endtask

  // Input driver: retire accepted beats, present each requester's next beat
  initial begin
    acc_mask = '0;
    present();
    forever begin
      @(negedge clk);
      acc_mask = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          bit done;
          done = 1'b0;
          for (int k = 0; k < inq.size(); k++) begin
            if (!done && inq[k].id == i) begin
              inq.delete(k);
              done = 1'b1;
            end
          end
        end
      end
      present();
    end
  end

  // Output monitor: hold stability under backpressure and scoreboard compare
  initial begin
    exp_t e;
    logic hold;
    logic [15:0] pd;
    logic [1:0]  pid;
    logic        pl;
    logic [23:0] ps;
    hold = 1'b0; pd = '0; pid = '0; pl = 1'b0; ps = '0;
    forever begin
      @(negedge clk);
      if (hold && mon_en && rst_n) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(pd));
        chk("hold_id", 32'(out_id), 32'(pid));
        chk("hold_last", 32'(out_last), 32'(pl));
        chk("hold_sum", 32'(out_sum), 32'(ps));
      end
      hold = out_valid && !out_ready;
      pd = out_data; pid = out_id; pl = out_last; ps = out_sum;
      if (mon_en && rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got data 0x%0h id %0d, expected no output", out_data, out_id);
        end else begin
          e = expq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_id", 32'(out_id), 32'(e.id));
          chk("out_last", 32'(out_last), 32'(e.l));
          if (e.l) chk("out_sum", 32'(out_sum), 32'(e.s));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int t, t_acc, t_out, run;
    bit ended;
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Reset mid-row, then the pointer must restart at requester 0
    @(negedge clk);
    in_beat(2, 8'hFC, 1'b1);
    exp_beat(2, 16'h4000, 1'b1);
    wait_drain("t1_pre_row");
    mon_en = 1'b0;
    for (int k = 0; k < 6; k++) in_beat(3, 8'h00, (k == 5));
    repeat (4) @(negedge clk);
    chk("t1_midrow_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    inq.delete();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("t1_rst_out_valid", 32'(out_valid), 32'd0);
      chk("t1_rst_req_ready", 32'(req_ready), 32'd0);
    end
    inq.delete();
    expq.delete();
    sum_m = '0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    in_beat(3, 8'h00, 1'b1);
    in_beat(0, 8'hFC, 1'b1);
    exp_beat(0, 16'h4000, 1'b1);
    exp_beat(3, 16'h8000, 1'b1);
    wait_drain("t1_after_reset");

    // Arbitration: all requesters with 2-beat rows, grant order 0,1,2,3,0
    @(negedge clk);
    in_beat(0, 8'hFC, 1'b0); in_beat(0, 8'hF8, 1'b1);
    in_beat(0, 8'h00, 1'b0); in_beat(0, 8'h00, 1'b1);
    in_beat(1, 8'hF4, 1'b0); in_beat(1, 8'hFC, 1'b1);
    in_beat(2, 8'h04, 1'b0); in_beat(2, 8'hFF, 1'b1);
    in_beat(3, 8'h80, 1'b0); in_beat(3, 8'hF0, 1'b1);
    exp_beat(0, 16'h4000, 1'b0); exp_beat(0, 16'h2000, 1'b1);
    exp_beat(1, 16'h1000, 1'b0); exp_beat(1, 16'h4000, 1'b1);
    exp_beat(2, 16'h8000, 1'b0); exp_beat(2, 16'h6BA2, 1'b1);
    exp_beat(3, 16'h0000, 1'b0); exp_beat(3, 16'h0800, 1'b1);
    exp_beat(0, 16'h8000, 1'b0); exp_beat(0, 16'h8000, 1'b1);
    wait_drain("t3_arb");

    // Single row on requester 1, row sum 0x00E000
    in_beat(1, 8'h00, 1'b0); in_beat(1, 8'hFC, 1'b0); in_beat(1, 8'hF8, 1'b1);
    exp_beat(1, 16'h8000, 1'b0); exp_beat(1, 16'h4000, 1'b0); exp_beat(1, 16'h2000, 1'b1);
    wait_drain("t2_row");

    // Backpressure: out_ready low for 5 cycles mid-row
    in_beat(2, 8'hFC, 1'b0); in_beat(2, 8'hF8, 1'b0);
    in_beat(2, 8'hF4, 1'b0); in_beat(2, 8'hF0, 1'b1);
    exp_beat(2, 16'h4000, 1'b0); exp_beat(2, 16'h2000, 1'b0);
    exp_beat(2, 16'h1000, 1'b0); exp_beat(2, 16'h0800, 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t4_first_out", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      chk("t4_stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain("t4_backpressure");

    // Boundaries: most negative input, positive clamp, 256-beat row cap
    in_beat(3, 8'h80, 1'b0); in_beat(3, 8'h05, 1'b1);
    exp_beat(3, 16'h0000, 1'b0); exp_beat(3, 16'h8000, 1'b1);
    wait_drain("t5_clamp");
    for (int k = 0; k < 256; k++) begin
      in_beat(0, 8'h00, 1'b0);
      exp_beat(0, 16'h8000, (k == 255));
    end
    in_beat(0, 8'hFC, 1'b1);
    exp_beat(0, 16'h4000, 1'b1);
    wait_drain("t5_row_cap");

    // Throughput: 8 back-to-back outputs, first one cycle after first accept
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      in_beat(1, 8'h00, (k == 7));
      exp_beat(1, 16'h8000, (k == 7));
    end
    t = 0; t_acc = -1; t_out = -1; run = 0; ended = 1'b0;
    while (t < 40) begin
      @(negedge clk);
      if (t_acc < 0 && req_valid[1] && req_ready[1]) t_acc = t;
      if (out_valid && !ended) begin
        if (t_out < 0) t_out = t;
        run++;
      end else if (run > 0) begin
        ended = 1'b1;
      end
      t++;
    end
    chk("t6_first_latency", 32'(t_out - t_acc), 32'd1);
    chk("t6_run_length", 32'(run), 32'd8);
    wait_drain("t6_throughput");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
